seq_divider: RTL and testbench
==============================

Name: seq_divider

Overview:
- Parametrised multi-cycle restoring divider; successor to the single-cycle DIV path in the Datapath ALU.
- Produces quotient (to LO) and remainder (to HI).
- Supports signed and unsigned operation per request, with a start/busy/done handshake so the control unit can stall across divide states.
- Sits beside the ALU and drives the Z-high/Z-low capture path.

Parameters:
- WIDTH, 32, operand/result width in bits (≥4); iteration count equals WIDTH.

Ports:
- Clock  in  1  system clock; all state updates on the rising edge.
- Clear  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only in IDLE or DONE.
- signed_op  in  1  1 = two's-complement divide, 0 = unsigned; captured with start.
- dividend  in  WIDTH  numerator; captured with start.
- divisor  in  WIDTH  denominator; captured with start.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse; results are valid from this cycle onward.
- quotient_lo  out  WIDTH  quotient; held until the next accepted start.
- remainder_hi  out  WIDTH  remainder; held until the next accepted start.
- dz  out  1  divide-by-zero flag; present only with DIV_ZERO_TRAP_EN.

Behaviour:
- Reset (Clear=1, asynchronous): state=IDLE; busy=0, done=0, quotient_lo=0, remainder_hi=0, dz=0; iteration counter and internal registers=0.
- Clear mid-operation aborts immediately. No done is produced for the aborted operation.
- States: IDLE, RUN, FIX, DONE.
- IDLE: start=1 at edge k captures operands and mode, converts signed operands to magnitudes, records sign_q = sign(dividend) XOR sign(divisor) and sign_r = sign(dividend), sets count=0 -> RUN.
- RUN: one restoring step per cycle.
  - Shift {rem,quo} left by 1.
  - Trial = rem − divisor_mag.
  - If trial is non-negative, rem=trial and quo LSB=1.
  - count increments; after WIDTH steps -> FIX.
- FIX: in signed mode, negate quo if sign_q=1 and negate rem if sign_r=1. Load quotient_lo/remainder_hi -> DONE.
- DONE: done=1 for exactly one cycle -> IDLE. A start seen in DONE is accepted as if in IDLE (back-to-back, no bubble).
- Latency: start at edge k; done high after edge k+WIDTH+2; busy high after edges k+1 … k+WIDTH+1.
- start while busy: ignored, with no effect on the operation in flight.
- Signed semantics: quotient truncates toward zero; remainder takes the dividend's sign; dividend = q·divisor + r always holds.
- Signed overflow (most-negative / −1): quotient_lo = most-negative, remainder_hi = 0 (wraps, no flag).
- Magnitude arithmetic uses a WIDTH+1-bit remainder so that the most-negative magnitude is handled.
- Divide by zero (macro absent): runs the full WIDTH+2 cycles. quotient_lo = all ones, remainder_hi = dividend, in both modes; no sign fix-up is applied.

Optional Feature:
- DIV_ZERO_TRAP_EN
  - Defined:
    - dz port exists.
    - divisor==0 at start goes IDLE -> DONE directly, so done asserts after edge k+1.
    - quotient_lo=0, remainder_hi=0, dz=1 in the same cycle as done.
    - dz stays high until the next accepted start or Clear.
  - Undefined:
    - no dz port.
    - divide by zero behaves as stated in Behaviour.

Decomposition:
- Package div_pkg:
  - state enum (IDLE, RUN, FIX, DONE);
  - DIV_WIDTH_DEFAULT=32;
  - counter width function clog2(WIDTH+1).
- Sub-module div_step: combinational single restoring iteration.
  - Inputs: rem, quo, divisor_mag.
  - Outputs: next rem, next quo.
  - Instantiated once in seq_divider.

Test Plan:
- Unsigned 0x14 / 0x12 (WIDTH=32) -> quotient_lo=0x00000001, remainder_hi=0x00000002; done exactly 34 cycles after the start edge; busy high for 33 cycles.
- Signed 0xFFFFFFF9 (−7) / 0x2 -> quotient_lo=0xFFFFFFFD, remainder_hi=0xFFFFFFFF. Unsigned, same operands -> 0x7FFFFFFC, 0x00000001.
- Signed 0x80000000 / 0xFFFFFFFF -> quotient_lo=0x80000000, remainder_hi=0. Unsigned 0xFFFFFFFF / 1 -> 0xFFFFFFFF, 0.
- Divide by zero, dividend 0x1234:
  - macro absent -> after 34 cycles, 0xFFFFFFFF / 0x00001234;
  - DIV_ZERO_TRAP_EN -> done after 1 cycle, outputs 0 / 0, dz=1.
- Clear asserted between edges at cycle 10 of a run -> outputs zero asynchronously, no done pulse. A new start then completes normally.
- Back-to-back: start held high through DONE with new operands 100/7 -> second op accepted at the DONE edge; done again 34 cycles later with 14 / 2. A start pulsed mid-run is ignored.

Source files
------------

// File: rtl/div_pkg.sv
// ============================================================================
// Module  : div_pkg
// Purpose : Shared types and sizing helpers for the sequential divider.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package div_pkg;

  localparam int DIV_WIDTH_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

  // Counter must be able to hold the value WIDTH itself.
  function automatic int count_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/div_step.sv
// ============================================================================
// Module  : div_step
// Purpose : One combinational restoring-division iteration (shift, trial, keep).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic [WIDTH:0]   rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor_mag,
  output logic [WIDTH:0]   rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH+1:0] w_shift;
  logic [WIDTH:0]   w_diff;
  logic             w_ge;

  always_comb begin
    w_shift  = {rem, quo[WIDTH-1]};
    w_ge     = (w_shift >= {2'b00, divisor_mag});
    // When the trial succeeds the difference is below the divisor, so
    // WIDTH+1 bits hold it exactly.
    w_diff   = w_shift[WIDTH:0] - {1'b0, divisor_mag};
    rem_next = w_ge ? w_diff : w_shift[WIDTH:0];
    quo_next = {quo[WIDTH-2:0], w_ge};
  end

endmodule

`default_nettype wire

// File: rtl/seq_divider.sv
// ============================================================================
// Module  : seq_divider
// Purpose : Multi-cycle signed/unsigned restoring divider with start/busy/done
//           handshake. Optional macro DIV_ZERO_TRAP_EN adds the dz trap path.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic             Clock,
  input  logic             Clear,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient_lo,
  output logic [WIDTH-1:0] remainder_hi
`ifdef DIV_ZERO_TRAP_EN
  ,
  output logic             dz
`endif
);

  localparam int                 c_CNT_W = count_width(WIDTH);
  localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

`ifdef DIV_ZERO_TRAP_EN
  localparam logic c_TRAP_EN = 1'b1;
`else
  localparam logic c_TRAP_EN = 1'b0;
`endif

  div_state_t         r_state;
  div_state_t         w_next_state;

  logic [WIDTH:0]     r_rem;
  logic [WIDTH-1:0]   r_quo;
  logic [WIDTH-1:0]   r_dmag;
  logic [c_CNT_W-1:0] r_count;
  logic               r_signed;
  logic               r_sign_q;
  logic               r_sign_r;
  logic               r_div_zero;
  logic               r_trap;

  logic               w_accept;
  logic               w_div_zero;
  logic               w_dvd_neg;
  logic               w_dvs_neg;
  logic [WIDTH-1:0]   w_dvd_mag;
  logic [WIDTH-1:0]   w_dvs_mag;
  logic [WIDTH:0]     w_rem_next;
  logic [WIDTH-1:0]   w_quo_next;
  logic [WIDTH-1:0]   w_q_fix;
  logic [WIDTH-1:0]   w_r_fix;

  always_comb begin
    w_accept   = start && ((r_state == IDLE) || (r_state == DONE));
    w_div_zero = (divisor == '0);
    w_dvd_neg  = signed_op & dividend[WIDTH-1];
    w_dvs_neg  = signed_op & divisor[WIDTH-1];
    w_dvd_mag  = w_dvd_neg ? -dividend : dividend;
    w_dvs_mag  = w_dvs_neg ? -divisor  : divisor;
    // A zero divisor leaves the quotient all ones; restoring the remainder's
    // sign returns the original dividend in both modes.
    w_q_fix    = (r_signed && r_sign_q && !r_div_zero) ? -r_quo : r_quo;
    w_r_fix    = (r_signed && r_sign_r) ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0];
  end

  div_step #(
    .WIDTH       (WIDTH)
  ) u_step (
    .rem         (r_rem),
    .quo         (r_quo),
    .divisor_mag (r_dmag),
    .rem_next    (w_rem_next),
    .quo_next    (w_quo_next)
  );

  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE, DONE: begin
        if (start) begin
          w_next_state = (c_TRAP_EN && w_div_zero) ? DONE : RUN;
        end else begin
          w_next_state = IDLE;
        end
      end
      RUN: begin
        if (r_count == c_LAST) begin
          w_next_state = FIX;
        end
      end
      FIX:     w_next_state = DONE;
      default: w_next_state = IDLE;
    endcase
  end

  // busy/done are registered copies of the state, so they lag it by a cycle.
  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      busy         <= 1'b0;
      done         <= 1'b0;
      quotient_lo  <= '0;
      remainder_hi <= '0;
      r_rem        <= '0;
      r_quo        <= '0;
      r_dmag       <= '0;
      r_count      <= '0;
      r_signed     <= 1'b0;
      r_sign_q     <= 1'b0;
      r_sign_r     <= 1'b0;
      r_div_zero   <= 1'b0;
      r_trap       <= 1'b0;
    end else begin
      busy <= (r_state == RUN) || (r_state == FIX);
      done <= (r_state == DONE);

      if (r_state == FIX) begin
        quotient_lo  <= w_q_fix;
        remainder_hi <= w_r_fix;
      end else if ((r_state == DONE) && r_trap) begin
        quotient_lo  <= '0;
        remainder_hi <= '0;
      end

      if (w_accept) begin
        r_signed   <= signed_op;
        r_sign_q   <= w_dvd_neg ^ w_dvs_neg;
        r_sign_r   <= w_dvd_neg;
        r_dmag     <= w_dvs_mag;
        r_quo      <= w_dvd_mag;
        r_rem      <= '0;
        r_count    <= '0;
        r_div_zero <= w_div_zero;
        r_trap     <= c_TRAP_EN & w_div_zero;
      end else if (r_state == RUN) begin
        r_rem   <= w_rem_next;
        r_quo   <= w_quo_next;
        r_count <= r_count + 1'b1;
      end
    end
  end

`ifdef DIV_ZERO_TRAP_EN
  // The trap flag is raised with done; an operation accepted on that same
  // edge does not hide it.
  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      dz <= 1'b0;
    end else if ((r_state == DONE) && r_trap) begin
      dz <= 1'b1;
    end else if (w_accept) begin
      dz <= 1'b0;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_seq_divider.sv
// ============================================================================
// Module  : tb_seq_divider
// Purpose : Directed self-checking bench for seq_divider (WIDTH=32); honours
//           DIV_ZERO_TRAP_EN when defined.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_seq_divider;

  logic        Clock;
  logic        Clear;
  logic        start;
  logic        signed_op;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient_lo;
  logic [31:0] remainder_hi;
`ifdef DIV_ZERO_TRAP_EN
  logic        dz;
`endif

  int total = 0;
  int bad   = 0;
  int cyc;
  int bcnt;
  int dones;

  seq_divider #(.WIDTH(32)) dut (
    .Clock        (Clock),
    .Clear        (Clear),
    .start        (start),
    .signed_op    (signed_op),
    .dividend     (dividend),
    .divisor      (divisor),
    .busy         (busy),
    .done         (done),
    .quotient_lo  (quotient_lo),
    .remainder_hi (remainder_hi)
`ifdef DIV_ZERO_TRAP_EN
    ,
    .dz           (dz)
`endif
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // Issue a one-cycle start; returns just after the accepting edge.
  task automatic go(input logic s, input logic [31:0] a, input logic [31:0] b);
    signed_op = s;
    dividend  = a;
    divisor   = b;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  // Edges until done is seen (bounded); counts busy cycles along the way.
  task automatic wait_done(output int c, output int bc);
    c  = 0;
    bc = 0;
    do begin
      tick();
      c++;
      if (busy) bc++;
    end while (!done && c < 100);
  endtask

  task automatic run_op(input string tag, input logic s, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eq, input logic [31:0] er);
    go(s, a, b);
    wait_done(cyc, bcnt);
    chk({tag, ".lat"}, 32'(cyc), 32'd34);
    chk({tag, ".q"}, quotient_lo, eq);
    chk({tag, ".r"}, remainder_hi, er);
  endtask

  initial begin
    Clear     = 1'b1;
    start     = 1'b0;
    signed_op = 1'b0;
    dividend  = '0;
    divisor   = '0;
    #12;
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.q", quotient_lo, 32'd0);
    chk("rst.r", remainder_hi, 32'd0);
`ifdef DIV_ZERO_TRAP_EN
    chk("rst.dz", 32'(dz), 32'd0);
`endif
    Clear = 1'b0;
    tick();

    // Basic unsigned op with latency / busy-length / pulse-width checks.
    go(1'b0, 32'h14, 32'h12);
    chk("u1.busy_k", 32'(busy), 32'd0);
    wait_done(cyc, bcnt);
    chk("u1.lat", 32'(cyc), 32'd34);
    chk("u1.busycnt", 32'(bcnt), 32'd33);
    chk("u1.q", quotient_lo, 32'h1);
    chk("u1.r", remainder_hi, 32'h2);
    tick();
    chk("u1.pulse", 32'(done), 32'd0);
    chk("u1.hold_q", quotient_lo, 32'h1);

    run_op("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    run_op("u_m7_2", 1'b0, 32'hFFFF_FFF9, 32'h2, 32'h7FFF_FFFC, 32'h0000_0001);
    run_op("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0);
    run_op("u_max1", 1'b0, 32'hFFFF_FFFF, 32'h1, 32'hFFFF_FFFF, 32'h0);
    run_op("s_7_m2", 1'b1, 32'h7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h1);

`ifdef DIV_ZERO_TRAP_EN
    go(1'b0, 32'h1234, 32'h0);
    wait_done(cyc, bcnt);
    chk("dz.lat", 32'(cyc), 32'd1);
    chk("dz.q", quotient_lo, 32'h0);
    chk("dz.r", remainder_hi, 32'h0);
    chk("dz.flag", 32'(dz), 32'd1);
    tick();
    chk("dz.pulse", 32'(done), 32'd0);
    chk("dz.sticky", 32'(dz), 32'd1);
    go(1'b0, 32'd9, 32'd4);
    chk("dz.clear", 32'(dz), 32'd0);
    wait_done(cyc, bcnt);
    chk("dz.next_q", quotient_lo, 32'd2);
`else
    run_op("u_dz", 1'b0, 32'h1234, 32'h0, 32'hFFFF_FFFF, 32'h0000_1234);
    run_op("s_dz", 1'b1, 32'hFFFF_FFF0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFF0);
`endif

    // A start pulsed mid-run must not disturb the operation in flight.
    go(1'b0, 32'd1000, 32'd3);
    repeat (5) tick();
    dividend = 32'd5;
    divisor  = 32'd5;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    wait_done(cyc, bcnt);
    chk("ign.lat", 32'(cyc), 32'd28);
    chk("ign.q", quotient_lo, 32'd333);
    chk("ign.r", remainder_hi, 32'd1);

    // Back-to-back: start held high through DONE with new operands.
    signed_op = 1'b0;
    dividend  = 32'hFFFF_FFFF;
    divisor   = 32'h1;
    start     = 1'b1;
    tick();
    dividend  = 32'd100;
    divisor   = 32'd7;
    wait_done(cyc, bcnt);
    start     = 1'b0;
    chk("b2b.lat1", 32'(cyc), 32'd34);
    chk("b2b.q1", quotient_lo, 32'hFFFF_FFFF);
    chk("b2b.r1", remainder_hi, 32'h0);
    wait_done(cyc, bcnt);
    chk("b2b.lat2", 32'(cyc), 32'd34);
    chk("b2b.busy2", 32'(bcnt), 32'd33);
    chk("b2b.q2", quotient_lo, 32'd14);
    chk("b2b.r2", remainder_hi, 32'd2);

    // Asynchronous Clear in the middle of a run.
    go(1'b1, 32'hFFFF_FFF9, 32'h2);
    repeat (10) tick();
    #2;
    Clear = 1'b1;
    #1;
    chk("clr.q", quotient_lo, 32'h0);
    chk("clr.r", remainder_hi, 32'h0);
    chk("clr.busy", 32'(busy), 32'd0);
    #1;
    Clear = 1'b0;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) dones++;
    end
    chk("clr.nodone", 32'(dones), 32'd0);
    run_op("clr.after", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
